// File: rtl/fma_issue_if.sv
// Request/issue and stage-control bundle between the requesters, the FMA
// issue controller and the FMA datapath stage registers.
interface fma_issue_if #(
    parameter int NREQ  = 4,
    parameter int LAT   = 3,
    parameter int TAG_W = 4
);
    localparam int SRC_W = $clog2(NREQ);

    logic [NREQ-1:0]       req_valid;
    logic [2*NREQ-1:0]     req_mode;
    logic [2*NREQ-1:0]     req_prec;
    logic [TAG_W*NREQ-1:0] req_tag;
    logic [NREQ-1:0]       req_ready;
    logic                  flush;
    logic                  out_ready;
    logic                  stg_adv;
    logic [LAT-1:0]        stg_valid;
    logic [2*LAT-1:0]      stg_mode;
    logic [2*LAT-1:0]      stg_prec;
    logic                  out_valid;
    logic [TAG_W-1:0]      out_tag;
    logic [SRC_W-1:0]      out_src;
    logic                  busy;

    modport slave (
        input  req_valid, req_mode, req_prec, req_tag, flush, out_ready,
        output req_ready, stg_adv, stg_valid, stg_mode, stg_prec,
               out_valid, out_tag, out_src, busy
    );

    modport master (
        output req_valid, req_mode, req_prec, req_tag, flush, out_ready,
        input  req_ready, stg_adv, stg_valid, stg_mode, stg_prec,
               out_valid, out_tag, out_src, busy
    );
endinterface

// File: rtl/fma_issue_ctrl.sv
// Round-robin issue controller for a shared LAT-stage FMA pipe; tracks each op's
// mode/prec/tag/source per stage. Define PERF_CNT_EN for issue/stall counters.
module fma_issue_ctrl #(
    parameter int NREQ  = 4,
    parameter int LAT   = 3,
    parameter int TAG_W = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    fma_issue_if.slave  bus
`ifdef PERF_CNT_EN
   ,output logic [31:0] perf_issued,
    output logic [31:0] perf_stall
`endif
);
    localparam int SRC_W = $clog2(NREQ);

    typedef struct packed {
        logic [1:0]       mode;
        logic [1:0]       prec;
        logic [TAG_W-1:0] tag;
        logic [SRC_W-1:0] src;
    } op_t;

    op_t              stg_q [LAT];
    op_t              new_op;
    logic [LAT-1:0]   vld_pipe;
    logic [SRC_W-1:0] rr;
    logic [SRC_W-1:0] gnt_idx;
    logic             gnt_any;
    logic             stall;
    int               idx;

    assign stall = vld_pipe[LAT-1] & ~bus.out_ready;

    // First pending requester at or after rr wins; nothing is granted while
    // the pipe is frozen, flushing, or in reset.
    always_comb begin
        bus.req_ready = '0;
        gnt_idx       = '0;
        gnt_any       = 1'b0;
        idx           = 0;
        if (rst_n && !stall && !bus.flush) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = (int'(rr) + k) % NREQ;
                if (!gnt_any && bus.req_valid[idx]) begin
                    gnt_any            = 1'b1;
                    gnt_idx            = SRC_W'(idx);
                    bus.req_ready[idx] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        new_op.mode = bus.req_mode[2*gnt_idx +: 2];
        new_op.prec = bus.req_prec[2*gnt_idx +: 2];
        new_op.tag  = bus.req_tag[TAG_W*gnt_idx +: TAG_W];
        new_op.src  = gnt_idx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            rr       <= '0;
            for (int k = 0; k < LAT; k++) stg_q[k] <= '0;
        end else begin
            if (gnt_any)
                rr <= (gnt_idx == SRC_W'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
            if (bus.flush) begin
                vld_pipe <= '0;
            end else if (!stall) begin
                vld_pipe <= {vld_pipe[LAT-2:0], gnt_any};
                // Bubbles keep the stale fields; only the valid bit matters.
                if (gnt_any) stg_q[0] <= new_op;
                for (int k = 1; k < LAT; k++) stg_q[k] <= stg_q[k-1];
            end
        end
    end

    always_comb begin
        bus.stg_mode = '0;
        bus.stg_prec = '0;
        for (int k = 0; k < LAT; k++) begin
            bus.stg_mode[2*k +: 2] = stg_q[k].mode;
            bus.stg_prec[2*k +: 2] = stg_q[k].prec;
        end
    end

    assign bus.stg_adv   = ~stall;
    assign bus.stg_valid = vld_pipe;
    assign bus.out_valid = vld_pipe[LAT-1];
    assign bus.out_tag   = stg_q[LAT-1].tag;
    assign bus.out_src   = stg_q[LAT-1].src;
    assign bus.busy      = |vld_pipe;

`ifdef PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_issued <= '0;
            perf_stall  <= '0;
        end else if (bus.flush) begin
            perf_issued <= '0;
            perf_stall  <= '0;
        end else begin
            if (gnt_any) perf_issued <= perf_issued + 32'd1;
            if (stall)   perf_stall  <= perf_stall + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_fma_issue_ctrl.sv
// Directed-vector bench for fma_issue_ctrl (NREQ=4, LAT=3, TAG_W=4).
module tb_fma_issue_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tot = 0;
    int   n_bad = 0;

    fma_issue_if #(.NREQ(4), .LAT(3), .TAG_W(4)) bus ();

`ifdef PERF_CNT_EN
    logic [31:0] perf_issued, perf_stall;
    fma_issue_ctrl #(.NREQ(4), .LAT(3), .TAG_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave),
        .perf_issued(perf_issued), .perf_stall(perf_stall));
`else
    fma_issue_ctrl #(.NREQ(4), .LAT(3), .TAG_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave));
`endif

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid = '0;
        bus.req_mode  = '0;
        bus.req_prec  = '0;
        bus.req_tag   = {4'h3, 4'h2, 4'h1, 4'h0};
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        #12;
        chk("rst_ready", bus.req_ready, 0);
        chk("rst_valid", bus.stg_valid, 0);
        chk("rst_out",   bus.out_valid, 0);
        chk("rst_busy",  bus.busy, 0);
        chk("rst_adv",   bus.stg_adv, 1);
        step();
        rst_n = 1'b1;
        step();

        // round robin with all requesters pending
        for (int c = 0; c < 8; c++) begin
            bus.req_valid = 4'b1111;
            #1;
            chk("rr_grant", bus.req_ready, 64'(1 << (c % 4)));
            chk("rr_oval", bus.out_valid, (c >= 3) ? 1 : 0);
            if (c >= 3) begin
                chk("rr_src", bus.out_src, 64'((c - 3) % 4));
                chk("rr_tag", bus.out_tag, 64'((c - 3) % 4));
            end
            step();
        end
        bus.req_valid = '0;
        step(); step(); step();
        #1;
        chk("rr_drain_busy", bus.busy, 0);

        // single op through the pipe, rr = 0
        bus.req_valid = 4'b0100;
        bus.req_mode  = 8'b00_01_00_00;
        bus.req_prec  = 8'b00_10_00_00;
        bus.req_tag   = {4'h3, 4'hA, 4'h1, 4'h0};
        #1;
        chk("one_grant", bus.req_ready, 4'b0100);
        step();
        bus.req_valid = '0;
        #1;
        chk("one_v0", bus.stg_valid, 3'b001);
        chk("one_m0", bus.stg_mode[1:0], 2'b01);
        chk("one_p0", bus.stg_prec[1:0], 2'b10);
        step(); #1;
        chk("one_v1", bus.stg_valid, 3'b010);
        chk("one_m1", bus.stg_mode[3:2], 2'b01);
        step(); #1;
        chk("one_oval", bus.out_valid, 1);
        chk("one_tag",  bus.out_tag, 4'hA);
        chk("one_src",  bus.out_src, 2);
        chk("one_busy", bus.busy, 1);
        step(); #1;
        chk("one_idle", bus.busy, 0);

        // fill pipe (rr = 3 -> grants 3,0,1) then stall 5 cycles
        bus.req_valid = 4'b1111;
        #1; chk("st_g3", bus.req_ready, 4'b1000); step();
        #1; chk("st_g0", bus.req_ready, 4'b0001); step();
        #1; chk("st_g1", bus.req_ready, 4'b0010); step();
        bus.out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("st_ready", bus.req_ready, 0);
            chk("st_adv",   bus.stg_adv, 0);
            chk("st_valid", bus.stg_valid, 3'b111);
            chk("st_src",   bus.out_src, 3);
            step();
        end
        bus.out_ready = 1'b1;
        bus.req_valid = '0;
        #1; chk("dr_src3", bus.out_src, 3); chk("dr_adv", bus.stg_adv, 1);
        step(); #1; chk("dr_src0", bus.out_src, 0);
        step(); #1; chk("dr_src1", bus.out_src, 1);
        step(); #1; chk("dr_empty", bus.out_valid, 0);

        // bubble pattern, rr = 2
        bus.req_valid = 4'b0100;
        #1; chk("bb_g2", bus.req_ready, 4'b0100);
        step();
        bus.req_valid = '0;
        #1; chk("bb_001", bus.stg_valid, 3'b001);
        step();
        bus.req_valid = 4'b0001;
        #1; chk("bb_010", bus.stg_valid, 3'b010); chk("bb_g0", bus.req_ready, 4'b0001);
        step();
        bus.req_valid = '0;
        #1; chk("bb_101", bus.stg_valid, 3'b101);
        bus.out_ready = 1'b0;
        #1; chk("bb_adv", bus.stg_adv, 0);
        step(); #1; chk("bb_hold1", bus.stg_valid, 3'b101);
        step(); #1; chk("bb_hold2", bus.stg_valid, 3'b101);
        bus.out_ready = 1'b1;
        step(); #1; chk("bb_010b", bus.stg_valid, 3'b010);
        step(); #1; chk("bb_100",  bus.stg_valid, 3'b100);
        step(); #1; chk("bb_000",  bus.stg_valid, 3'b000);

        // flush with three in flight, rr = 1 -> grants 1,2,3
        bus.req_valid = 4'b1111;
        #1; chk("fl_g1", bus.req_ready, 4'b0010); step();
        #1; chk("fl_g2", bus.req_ready, 4'b0100); step();
        #1; chk("fl_g3", bus.req_ready, 4'b1000); step();
        bus.flush     = 1'b1;
        bus.req_valid = 4'b0010;
        #1;
        chk("fl_nogrant", bus.req_ready, 0);
        chk("fl_oval",    bus.out_valid, 1);
        step();
        bus.flush     = 1'b0;
        bus.req_valid = 4'b1111;
        #1;
        chk("fl_cleared", bus.stg_valid, 0);
        chk("fl_resume",  bus.req_ready, 4'b0001);
`ifdef PERF_CNT_EN
        chk("fl_pissued", perf_issued, 0);
        chk("fl_pstall",  perf_stall, 0);
`endif
        for (int c = 0; c < 7; c++) begin
            #1;
            chk("pc_grant", bus.req_ready, 64'(1 << (c % 4)));
            step();
        end
        bus.req_valid = '0;
        bus.out_ready = 1'b0;
        for (int c = 0; c < 5; c++) step();
        #1;
        chk("pc_full", bus.stg_valid, 3'b111);
`ifdef PERF_CNT_EN
        chk("pc_issued", perf_issued, 7);
        chk("pc_stall",  perf_stall, 5);
`endif

        // asynchronous reset mid-stream
        bus.out_ready = 1'b1;
        bus.req_valid = 4'b1111;
        step();
        #3;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", bus.stg_valid, 0);
        chk("ar_oval",  bus.out_valid, 0);
        chk("ar_busy",  bus.busy, 0);
        chk("ar_ready", bus.req_ready, 0);
        chk("ar_src",   bus.out_src, 0);
        chk("ar_tag",   bus.out_tag, 0);
`ifdef PERF_CNT_EN
        chk("ar_pissued", perf_issued, 0);
`endif
        step();
        rst_n = 1'b1;
        #1; chk("ar_rr0", bus.req_ready, 4'b0001);
        step(); #1; chk("ar_v0", bus.stg_valid, 3'b001);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule
